link_watchdog: RTL and testbench
================================

Name: link_watchdog

Overview:
- Passive monitor inserted on one NoC link directly downstream of the link fault injector, between it and the receiving router input port.
- Forwards all link signals unchanged and follows packet framing: header, size, service/payload, eop.
- Detects upstream starvation inside a packet (hang) and raises alarms.
- Records stall statistics and the identity of the stalled packet for the simulation/security monitor.

Parameters:
TIMEOUT, 64, consecutive starved in-packet cycles that declare a stall (legal range >=1)
CNT_W, 32, width of the packet and cycle counters

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
rx_i  in  1  flit valid from upstream (fault injector)
eop_i  in  1  end-of-packet sideband from upstream
data_i  in  32  flit data from upstream
cr_o  out  1  credit to upstream
rx_o  out  1  flit valid to router
eop_o  out  1  end-of-packet to router
data_o  out  32  flit data to router
cr_i  in  1  credit from router
stall_o  out  1  level: stall currently active
alarm_o  out  1  one-cycle pulse when a stall is declared
recover_o  out  1  one-cycle pulse when a stalled packet resumes
proto_err_o  out  1  one-cycle pulse on framing mismatch
hdr_o  out  16  header[15:0] of the last stalled packet
service_o  out  32  service flit of the last stalled packet (0 if the stall occurred before the service flit)
pkt_count_o  out  CNT_W  completed packets, saturating
stall_count_o  out  16  declared stalls, saturating
last_stall_o  out  CNT_W  starved cycles of the most recent completed stall
max_stall_o  out  CNT_W  maximum completed stall length

Behaviour:
- Passthrough is purely combinational with zero latency: rx_o=rx_i, eop_o=eop_i, data_o=data_i, cr_o=cr_i.
- received = rx_i && cr_i.
- Reset: FSM in HEADER; all registers and outputs 0.
- FSM:
  - HEADER: on received, latch data_i[15:0] as cur_hdr and clear cur_srv. If eop_i is also set, pulse proto_err_o and stay in HEADER. Otherwise go to SIZE.
  - SIZE: on received, remaining <= data_i. If eop_i is set: with data_i==0, complete the packet and go to HEADER; with data_i!=0, pulse proto_err_o and go to HEADER. Otherwise go to SERVICE if data_i!=0; if data_i==0, pulse proto_err_o and go to HEADER.
  - SERVICE: on received, latch cur_srv=data_i, decrement remaining, then go to PAYLOAD.
  - PAYLOAD: on received, decrement remaining.
- Termination and framing checks (apply in SERVICE and PAYLOAD):
  - received with eop_i and remaining==1: complete the packet, go to HEADER.
  - received with eop_i and remaining!=1: proto_err_o pulse, go to HEADER.
  - received without eop_i and remaining==1: proto_err_o pulse, go to HEADER. The trailing eop flit is then treated as a new header.
- Packet completion: pkt_count_o increments, saturating at all-ones.
- Gap counter:
  - Active only in SIZE, SERVICE and PAYLOAD.
  - Increments (saturating) on every cycle with rx_i==0.
  - Holds when rx_i==1 && cr_i==0; router backpressure is not starvation.
  - Clears to 0 on received and on any return to HEADER.
- Stall declaration: at the edge where the gap counter reaches TIMEOUT, while stall_o==0:
  - set stall_o;
  - pulse alarm_o in the same cycle stall_o first reads 1;
  - stall_count_o++ (saturating);
  - hdr_o <= cur_hdr, service_o <= cur_srv.
- Recovery: received while stall_o==1:
  - clear stall_o, pulse recover_o;
  - last_stall_o <= gap counter value;
  - max_stall_o <= max(max_stall_o, gap counter value).
- Simultaneous events: a recovery flit that also ends the packet performs recovery, packet completion and HEADER return all at the same edge.
- proto_err_o while stalled: performs recovery as above, then returns to HEADER.
- Between packets (HEADER state) idle time is never counted.
- Reset mid-stall: everything clears; no recover_o pulse is generated.

Test Plan:
1. TIMEOUT=4; packet hdr 0x0102, size 3, service 1, two payloads, eop on last, no gaps -> pkt_count_o=1, alarm_o never set, proto_err_o never set.
2. TIMEOUT=4; same packet with rx_i low for 10 cycles after the service flit -> alarm_o pulses at the 4th starved edge, stall_o high for 7 cycles, recover_o on the next flit, last_stall_o=10, max_stall_o=10, hdr_o=0x0102, service_o=1, stall_count_o=1.
3. TIMEOUT=4; 20 cycles with rx_i=1, cr_i=0 mid-packet -> no stall. Separately, 30 idle cycles in HEADER -> no stall.
4. TIMEOUT=4; two stalls of 6 and 5 cycles in successive packets -> stall_count_o=2, last_stall_o=5, max_stall_o=6.
5. Packet with size 3 but eop on the 2nd post-size flit -> proto_err_o pulse, pkt_count_o unchanged, next flit parsed as header.
6. Assert rst_ni low while stall_o=1 -> all outputs 0 immediately, no recover_o pulse; passthrough is unaffected throughout.

Source files
------------

// File: rtl/link_watchdog.sv
// Passive NoC link monitor: forwards the link unchanged, tracks packet framing and
// flags in-packet upstream starvation (stall), recovery and framing errors.
module link_watchdog #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             rx_i,
    input  logic             eop_i,
    input  logic [31:0]      data_i,
    output logic             cr_o,
    output logic             rx_o,
    output logic             eop_o,
    output logic [31:0]      data_o,
    input  logic             cr_i,
    output logic             stall_o,
    output logic             alarm_o,
    output logic             recover_o,
    output logic             proto_err_o,
    output logic [15:0]      hdr_o,
    output logic [31:0]      service_o,
    output logic [CNT_W-1:0] pkt_count_o,
    output logic [15:0]      stall_count_o,
    output logic [CNT_W-1:0] last_stall_o,
    output logic [CNT_W-1:0] max_stall_o
);

    typedef enum logic [1:0] {StHeader, StSize, StService, StPayload} state_e;

    state_e           r_state;
    logic [15:0]      r_cur_hdr;
    logic [31:0]      r_cur_srv;
    logic [31:0]      r_remaining;
    logic [CNT_W-1:0] r_gap;
    logic             r_stall;
    logic             r_alarm;
    logic             r_recover;
    logic             r_perr;
    logic [15:0]      r_hdr;
    logic [31:0]      r_srv;
    logic [CNT_W-1:0] r_pkt_count;
    logic [15:0]      r_stall_count;
    logic [CNT_W-1:0] r_last_stall;
    logic [CNT_W-1:0] r_max_stall;

    logic             w_received;
    logic             w_last;
    logic             w_complete;
    logic             w_perr;
    logic             w_end;
    logic [CNT_W-1:0] w_gap_inc;

    assign rx_o   = rx_i;
    assign eop_o  = eop_i;
    assign data_o = data_i;
    assign cr_o   = cr_i;

    assign w_received = rx_i & cr_i;
    assign w_last     = (r_remaining == 32'd1);
    assign w_gap_inc  = (r_gap == '1) ? r_gap : r_gap + 1'b1;

    // Framing decode for the flit accepted this cycle.
    always_comb begin
        w_complete = 1'b0;
        w_perr     = 1'b0;
        if (w_received) begin
            case (r_state)
                StHeader: w_perr = eop_i;
                StSize: begin
                    if (eop_i) begin
                        w_complete = (data_i == 32'd0);
                        w_perr     = (data_i != 32'd0);
                    end else begin
                        w_perr     = (data_i == 32'd0);
                    end
                end
                default: begin
                    w_complete = eop_i & w_last;
                    w_perr     = eop_i ^ w_last;
                end
            endcase
        end
    end

    assign w_end = w_complete | w_perr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= StHeader;
            r_cur_hdr     <= '0;
            r_cur_srv     <= '0;
            r_remaining   <= '0;
            r_gap         <= '0;
            r_stall       <= 1'b0;
            r_alarm       <= 1'b0;
            r_recover     <= 1'b0;
            r_perr        <= 1'b0;
            r_hdr         <= '0;
            r_srv         <= '0;
            r_pkt_count   <= '0;
            r_stall_count <= '0;
            r_last_stall  <= '0;
            r_max_stall   <= '0;
        end else begin
            r_alarm   <= 1'b0;
            r_recover <= 1'b0;
            r_perr    <= w_perr;

            if (w_complete && r_pkt_count != '1) begin
                r_pkt_count <= r_pkt_count + 1'b1;
            end

            if (w_received) begin
                case (r_state)
                    StHeader: begin
                        r_cur_hdr <= data_i[15:0];
                        r_cur_srv <= '0;
                        if (!eop_i) r_state <= StSize;
                    end
                    StSize: begin
                        r_remaining <= data_i;
                        r_state     <= w_end ? StHeader : StService;
                    end
                    StService: begin
                        r_cur_srv   <= data_i;
                        r_remaining <= r_remaining - 32'd1;
                        r_state     <= w_end ? StHeader : StPayload;
                    end
                    default: begin
                        r_remaining <= r_remaining - 32'd1;
                        if (w_end) r_state <= StHeader;
                    end
                endcase
            end

            // Backpressure (rx_i high, cr_i low) holds the gap; only a silent link counts.
            if (r_state == StHeader || w_received) begin
                r_gap <= '0;
            end else if (!rx_i) begin
                r_gap <= w_gap_inc;
            end

            if (w_received && r_stall) begin
                r_stall      <= 1'b0;
                r_recover    <= 1'b1;
                r_last_stall <= r_gap;
                if (r_gap > r_max_stall) r_max_stall <= r_gap;
            end else if (r_state != StHeader && !rx_i && !r_stall &&
                         w_gap_inc == CNT_W'(TIMEOUT)) begin
                r_stall <= 1'b1;
                r_alarm <= 1'b1;
                r_hdr   <= r_cur_hdr;
                r_srv   <= r_cur_srv;
                if (r_stall_count != '1) r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

    assign stall_o       = r_stall;
    assign alarm_o       = r_alarm;
    assign recover_o     = r_recover;
    assign proto_err_o   = r_perr;
    assign hdr_o         = r_hdr;
    assign service_o     = r_srv;
    assign pkt_count_o   = r_pkt_count;
    assign stall_count_o = r_stall_count;
    assign last_stall_o  = r_last_stall;
    assign max_stall_o   = r_max_stall;

endmodule

// File: tb/tb_link_watchdog.sv
// Bench for link_watchdog: directed scenarios plus random traffic, all checked every
// cycle against a packet-level reference model.
module tb_link_watchdog;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CNT_W   = 32;

    logic             clk;
    logic             rst_n;
    logic             rx_i, eop_i, cr_i;
    logic [31:0]      data_i;
    logic             cr_o, rx_o, eop_o;
    logic [31:0]      data_o;
    logic             stall_o, alarm_o, recover_o, proto_err_o;
    logic [15:0]      hdr_o;
    logic [31:0]      service_o;
    logic [CNT_W-1:0] pkt_count_o;
    logic [15:0]      stall_count_o;
    logic [CNT_W-1:0] last_stall_o;
    logic [CNT_W-1:0] max_stall_o;

    link_watchdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rx_i         (rx_i),
        .eop_i        (eop_i),
        .data_i       (data_i),
        .cr_o         (cr_o),
        .rx_o         (rx_o),
        .eop_o        (eop_o),
        .data_o       (data_o),
        .cr_i         (cr_i),
        .stall_o      (stall_o),
        .alarm_o      (alarm_o),
        .recover_o    (recover_o),
        .proto_err_o  (proto_err_o),
        .hdr_o        (hdr_o),
        .service_o    (service_o),
        .pkt_count_o  (pkt_count_o),
        .stall_count_o(stall_count_o),
        .last_stall_o (last_stall_o),
        .max_stall_o  (max_stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int stall_hi = 0;

    // Reference model: packet position counted in flits, starvation in cycles.
    int          m_pos;      // 0 header next, 1 size next, n>=2: (n-1)th post-size flit next
    int unsigned m_size;
    int unsigned m_starve;
    bit          m_stall;
    logic [15:0] m_cur_hdr;
    logic [31:0] m_cur_srv;
    bit          e_alarm, e_recover, e_perr;
    logic [15:0] e_hdr;
    logic [31:0] e_srv;
    int unsigned e_pkts, e_stalls, e_last, e_max;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_size = 0; m_starve = 0; m_stall = 0;
        m_cur_hdr = '0; m_cur_srv = '0;
        e_alarm = 0; e_recover = 0; e_perr = 0;
        e_hdr = '0; e_srv = '0;
        e_pkts = 0; e_stalls = 0; e_last = 0; e_max = 0;
    endtask

    task automatic model_step(input bit rx, input bit eop, input logic [31:0] d, input bit cr);
        int k;
        e_alarm = 0; e_recover = 0; e_perr = 0;
        if (rx && cr) begin
            if (m_stall) begin
                m_stall = 0;
                e_recover = 1;
                e_last = m_starve;
                if (m_starve > e_max) e_max = m_starve;
            end
            m_starve = 0;
            if (m_pos == 0) begin
                m_cur_hdr = d[15:0];
                m_cur_srv = '0;
                if (eop) e_perr = 1; else m_pos = 1;
            end else if (m_pos == 1) begin
                m_size = d;
                if (eop) begin
                    if (d == 0) e_pkts++; else e_perr = 1;
                    m_pos = 0;
                end else if (d == 0) begin
                    e_perr = 1;
                    m_pos = 0;
                end else begin
                    m_pos = 2;
                end
            end else begin
                k = m_pos - 1;
                if (k == 1) m_cur_srv = d;
                if (eop) begin
                    if (k == int'(m_size)) e_pkts++; else e_perr = 1;
                    m_pos = 0;
                end else if (k == int'(m_size)) begin
                    e_perr = 1;
                    m_pos = 0;
                end else begin
                    m_pos++;
                end
            end
        end else if (m_pos != 0 && !rx) begin
            m_starve++;
            if (m_starve == TIMEOUT && !m_stall) begin
                m_stall = 1;
                e_alarm = 1;
                e_stalls++;
                e_hdr = m_cur_hdr;
                e_srv = m_cur_srv;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_stall"},   32'(stall_o),       32'(m_stall));
        chk({tag, "_alarm"},   32'(alarm_o),       32'(e_alarm));
        chk({tag, "_recover"}, 32'(recover_o),     32'(e_recover));
        chk({tag, "_perr"},    32'(proto_err_o),   32'(e_perr));
        chk({tag, "_hdr"},     32'(hdr_o),         32'(e_hdr));
        chk({tag, "_srv"},     service_o,          e_srv);
        chk({tag, "_pkts"},    pkt_count_o,        e_pkts);
        chk({tag, "_stalls"},  32'(stall_count_o), e_stalls);
        chk({tag, "_last"},    last_stall_o,       e_last);
        chk({tag, "_max"},     max_stall_o,        e_max);
    endtask

    task automatic check_pass(input string tag);
        chk({tag, "_rx_o"},   32'(rx_o),  32'(rx_i));
        chk({tag, "_eop_o"},  32'(eop_o), 32'(eop_i));
        chk({tag, "_data_o"}, data_o,     data_i);
        chk({tag, "_cr_o"},   32'(cr_o),  32'(cr_i));
    endtask

    // Entered and left at posedge+1.
    task automatic cycle(input bit rx, input bit eop, input logic [31:0] d, input bit cr,
                         input string tag);
        rx_i = rx; eop_i = eop; data_i = d; cr_i = cr;
        #1;
        check_pass(tag);
        @(posedge clk);
        model_step(rx, eop, d, cr);
        #1;
        if (stall_o) stall_hi++;
        check_outputs(tag);
    endtask

    task automatic flit(input logic [31:0] d, input bit eop, input string tag);
        cycle(1'b1, eop, d, 1'b1, tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, $urandom, 1'b1, tag);
    endtask

    task automatic do_reset();
        rx_i = 0; eop_i = 0; data_i = '0; cr_i = 1;
        rst_n = 1'b0;
        model_reset();
        #2;
        check_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int len;
        rst_n = 1'b1;
        rx_i = 0; eop_i = 0; data_i = '0; cr_i = 1;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Clean packet.
        flit(32'h0102, 0, "t1"); flit(3, 0, "t1"); flit(1, 0, "t1");
        flit(32'hAAAA, 0, "t1"); flit(32'hBBBB, 1, "t1");
        chk("t1_pkt_count", pkt_count_o, 1);

        // 10-cycle starvation after the service flit.
        stall_hi = 0;
        flit(32'h0102, 0, "t2"); flit(3, 0, "t2"); flit(1, 0, "t2");
        idle(10, "t2");
        flit(32'hCCCC, 0, "t2"); flit(32'hDDDD, 1, "t2");
        chk("t2_stall_cycles", stall_hi, 7);
        chk("t2_last", last_stall_o, 10);
        chk("t2_max", max_stall_o, 10);
        chk("t2_hdr", 32'(hdr_o), 32'h0102);
        chk("t2_srv", service_o, 1);
        chk("t2_stalls", 32'(stall_count_o), 1);

        // Backpressure mid-packet, then long idle between packets.
        flit(32'h0A0B, 0, "t3"); flit(3, 0, "t3"); flit(5, 0, "t3");
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, $urandom, 1'b0, "t3bp");
        flit(32'h1, 0, "t3"); flit(32'h2, 1, "t3");
        idle(30, "t3idle");
        chk("t3_stalls", 32'(stall_count_o), 1);

        // Two stalls in successive packets.
        do_reset();
        flit(32'h0011, 0, "t4"); flit(2, 0, "t4"); flit(7, 0, "t4");
        idle(6, "t4"); flit(32'h5, 1, "t4");
        flit(32'h0022, 0, "t4"); flit(2, 0, "t4");
        idle(5, "t4"); flit(9, 0, "t4"); flit(32'h6, 1, "t4");
        chk("t4_stalls", 32'(stall_count_o), 2);
        chk("t4_last", last_stall_o, 5);
        chk("t4_max", max_stall_o, 6);
        chk("t4_srv", service_o, 0);

        // Early eop, then the next flit is a fresh header.
        flit(32'h0033, 0, "t5"); flit(3, 0, "t5"); flit(4, 0, "t5");
        flit(32'h7, 1, "t5");
        chk("t5_pkts", pkt_count_o, 2);
        flit(32'h0303, 0, "t5"); flit(1, 0, "t5"); flit(8, 1, "t5");
        chk("t5_pkts_after", pkt_count_o, 3);

        // Reset while stalled.
        flit(32'h0044, 0, "t6"); flit(3, 0, "t6"); flit(2, 0, "t6");
        idle(6, "t6");
        chk("t6_stalled", 32'(stall_o), 1);
        rst_n = 1'b0;
        model_reset();
        rx_i = 1; eop_i = 1; data_i = $urandom; cr_i = 0;
        #1;
        check_outputs("t6_rst");
        check_pass("t6_rst");
        @(posedge clk);
        #1;
        check_outputs("t6_rst_hold");
        rst_n = 1'b1;
        idle(2, "t6_post");
        flit(32'h0055, 0, "t6"); flit(1, 0, "t6"); flit(3, 1, "t6");

        // Random traffic with occasional idle bursts.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                len = $urandom_range(1, 8);
                idle(len, "rnd_idle");
            end else begin
                cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4)),
                      ($urandom_range(0, 4) != 0), "rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
